// File: rtl/jk_sync_counter_pkg.sv
// Shared constants for the JK-based synchronous counter: JK cell modes and default width.
package jk_sync_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_mode_e;

endpackage

// File: rtl/jk_sync_counter_jk_cell.sv
// Single JK flip-flop with asynchronous active-low clear; qbar is registered alongside q.
module jk_cell
    import jk_sync_counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_q;
    logic q_d;
    logic qbar_q;

    always_comb begin
        q_d = q_q;
        case (jk_mode_e'({j, k}))
            JK_HOLD: q_d = q_q;
            JK_RST:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= 1'b0;
            qbar_q <= 1'b1;
        end else begin
            q_q    <= q_d;
            qbar_q <= ~q_d;
        end
    end

    assign q    = q_q;
    assign qbar = qbar_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Loadable up/down counter: one JK cell per bit, T-chain and load muxing drive J/K.
module jk_sync_counter
    import jk_sync_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    logic [WIDTH-1:0] t_d;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             carry;

    // Bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down).
    always_comb begin
        t_d   = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_d[i] = carry;
            carry  = carry & (up ? q[i] : qbar[i]);
        end
    end

    // din only reaches the cells while load is high, so an undriven din cannot leak in.
    always_comb begin
        j_d = '0;
        k_d = '0;
        if (load) begin
            j_d = din;
            k_d = ~din;
        end else if (en) begin
            j_d = t_d;
            k_d = t_d;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .j    (j_d[g]),
            .k    (k_d[g]),
            .q    (q[g]),
            .qbar (qbar[g])
        );
    end

    assign tc = en & ~load & (up ? (&q) : ~(|q));

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed-vector bench for jk_sync_counter, including a two-stage cascade.
module tb_jk_sync_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] q;
    logic [3:0] qbar;
    logic       tc;

    logic       cas_en;
    logic [3:0] lo_q, lo_qbar, hi_q, hi_qbar;
    logic       lo_tc, hi_tc;

    int errors = 0;
    int checks = 0;

    jk_sync_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .din(din), .q(q), .qbar(qbar), .tc(tc)
    );

    jk_sync_counter #(.WIDTH(4)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(cas_en), .up(1'b1), .load(1'b0),
        .din(4'h0), .q(lo_q), .qbar(lo_qbar), .tc(lo_tc)
    );

    jk_sync_counter #(.WIDTH(4)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(lo_tc), .up(1'b1), .load(1'b0),
        .din(4'h0), .q(hi_q), .qbar(hi_qbar), .tc(hi_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_q(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, q}, {28'd0, exp});
        check({tag, "_qbar"}, {28'd0, qbar}, {28'd0, ~exp});
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        up     = 1'b1;
        load   = 1'b0;
        din    = 4'h0;
        cas_en = 1'b0;
        step();
        step();
        check_q("reset", 4'h0);
        rst_n = 1'b1;
        #1;
        check("reset_tc", {31'd0, tc}, 32'd0);

        // count up 17 edges from 0
        en = 1'b1;
        up = 1'b1;
        #1;
        check("up_tc0", {31'd0, tc}, 32'd0);
        for (int k = 1; k <= 17; k++) begin
            step();
            check_q("up_q", 4'(k % 16));
            check("up_tc", {31'd0, tc}, {31'd0, (k % 16) == 15});
        end

        // load 2 then count down through wrap
        load = 1'b1;
        din  = 4'h2;
        #1;
        check("load_tc", {31'd0, tc}, 32'd0);
        step();
        check_q("ld2", 4'h2);
        load = 1'b0;
        up   = 1'b0;
        #1;
        check("dn_tc2", {31'd0, tc}, 32'd0);
        begin
            logic [3:0] dn_exp [4];
            dn_exp = '{4'h1, 4'h0, 4'hF, 4'hE};
            for (int k = 0; k < 4; k++) begin
                step();
                check_q("dn_q", dn_exp[k]);
                check("dn_tc", {31'd0, tc}, {31'd0, dn_exp[k] == 4'h0});
            end
        end

        // load priority over counting
        load = 1'b1;
        din  = 4'h5;
        step();
        check_q("ld5", 4'h5);
        load = 1'b1;
        en   = 1'b1;
        up   = 1'b1;
        din  = 4'hA;
        #1;
        check("ldpri_tc", {31'd0, tc}, 32'd0);
        step();
        check_q("ldpri", 4'hA);

        // load with en=0, then hold
        en   = 1'b0;
        din  = 4'h7;
        step();
        check_q("ld_en0", 4'h7);
        load = 1'b0;
        din  = 4'hC;
        for (int k = 0; k < 3; k++) begin
            step();
            check_q("hold", 4'h7);
        end
        check("hold_tc", {31'd0, tc}, 32'd0);

        // direction flip every cycle
        en = 1'b1;
        begin
            logic [3:0] fl_exp [4];
            fl_exp = '{4'h8, 4'h7, 4'h8, 4'h7};
            for (int k = 0; k < 4; k++) begin
                up = (k % 2 == 0);
                step();
                check_q("flip", fl_exp[k]);
            end
        end

        // async reset mid-count at 9, pending load discarded
        load = 1'b1;
        din  = 4'h9;
        step();
        check_q("ld9", 4'h9);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        #2;
        load  = 1'b1;
        din   = 4'h3;
        rst_n = 1'b0;
        #1;
        check_q("rst_async", 4'h0);
        step();
        step();
        check_q("rst_hold", 4'h0);
        load  = 1'b0;
        rst_n = 1'b1;
        #1;
        check_q("rst_rel", 4'h0);
        step();
        check_q("rst_first", 4'h1);

        // undriven din ignored while load=0
        en  = 1'b0;
        din = 4'bxxxx;
        step();
        check_q("din_x", 4'h1);
        din = 4'h0;

        // cascade of two 4-bit stages: 256 edges from 0
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        check("cas_start", {24'd0, hi_q, lo_q}, 32'd0);
        cas_en = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            step();
            check("cas", {24'd0, hi_q, lo_q}, 32'(k % 256));
        end
        check("cas_end", {24'd0, hi_q, lo_q}, 32'h00);
        check("cas_hibar", {28'd0, hi_qbar}, 32'hF);
        cas_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_sync_counter.md
Name: jk_sync_counter

Overview:
- Synchronous, loadable up/down binary counter built from one JK flip-flop per bit.
- Downstream consumer of the JK flip-flop stage: each bit's J/K drive is derived from lower-bit state, so every bit is a JK cell in toggle/hold/set/reset mode.
- Used as the event/divider counter in the sequential-logic lab set.
- Provides a terminal-count flag for cascading.

Parameters:
- WIDTH, default 4: counter width in bits (legal 2..16).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load, has priority over en.
- din  input  WIDTH  parallel load value.
- q  output  WIDTH  counter state, registered.
- qbar  output  WIDTH  bitwise complement of q, registered alongside q.
- tc  output  1  terminal count, combinational from q/en/up.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n=0 forces q=0 and qbar=all-ones immediately, independent of clk.
  - Outputs hold these values while rst_n=0.
  - First update occurs on the first rising clk edge after rst_n deasserts.
- Per-bit JK cell modes: JK=00 hold, 01 reset (q=0), 10 set (q=1), 11 toggle.
- Priority at each rising clk:
  - load=1: bit i gets J=din[i], K=~din[i]. Result q=din after 1 cycle, regardless of en/up.
  - load=0, en=1, up=1: T[0]=1 and T[i]=&q[i-1:0]; bit i gets J=K=T[i].
  - load=0, en=1, up=0: T[0]=1 and T[i]=&qbar[i-1:0]; bit i gets J=K=T[i].
  - load=0, en=0: all cells J=K=0, so q holds.
- Latency: q reflects the operation selected at edge n immediately after edge n. No pipelining.
- Wrap-around:
  - Up from all-ones gives 0.
  - Down from 0 gives all-ones.
  - Modulo 2^WIDTH, with no saturation.
- tc = en & ~load & (up ? (q==all-ones) : (q==0)).
  - tc is high in the cycle before the wrap.
  - Cascading: tc of a stage drives en of the next stage.
- Direction change mid-count takes effect at the next edge, with no glitch cycle.
- qbar must equal ~q at all times outside the reset transition.
- load with en=0 still loads.
- din sampled only when load=1.
- Reset asserted mid-operation:
  - q clears immediately.
  - A load or count pending at that moment is discarded.
- No X propagation from din when load=0.

Decomposition:
- Shared header/package holds the JK mode constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11, plus the default WIDTH.
- Sub-module jk_cell: a single JK flip-flop with ports clk, rst_n, j, k, q, qbar.
  - Asynchronous active-low reset to q=0.
  - Instantiated WIDTH times via generate.
- Top level contains only the T-chain/load muxing and the tc logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-count at q=4'h9 -> q=0 and qbar=4'hF immediately (before the next edge), and q stays 0 until the first edge after release.
- Count up: en=1, up=1, WIDTH=4, from 0 for 17 cycles -> q=1,2,…,15,0,1. tc=1 only while q=15.
- Count down with wrap: load din=4'h2, then en=1, up=0 -> q=2,1,0,15,14. tc=1 only while q=0.
- Load priority: q=4'h5, assert load=1, en=1, up=1, din=4'hA -> next q=4'hA, not 6, and tc=0 during the load cycle.
- Hold and direction flip:
  - en=0 for 3 cycles at q=7 -> q stays 7.
  - Then en=1 with up toggled every cycle -> q=8,7,8,7.
- Cascade: two instances, upper en tied to lower tc, count 256 edges from 0 -> combined {upper, lower} = 8'h00 after wrapping through 8'hFF, with the upper stage incrementing exactly when lower q goes 15→0.
